cv32e40p_permanent_fault_detector: RTL and testbench

// - Producer of permanent_faulty_alu/mult vectors consumed by the faulty-ALU decoder in the EX stage.
// - Counts per-replica voter mismatches for the 4 ALU and 4 MULT replicas; a replica whose count reaches THRESHOLD is latched permanently faulty.
// - Sticky flags clear only on reset or an explicit clear request; one-cycle event pulse reports each new fault.

---
 rtl/cv32e40p_permanent_fault_detector.sv | 158 +++++++++++++++
 tb/tb_cv32e40p_permanent_fault_detector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_permanent_fault_detector.sv
// Per-replica voter-mismatch counters that latch ALU/MULT replicas as permanently faulty.
// Optional leaky decay of error counters is enabled by defining PFD_LEAKY_DECAY_EN.
module cv32e40p_permanent_fault_detector #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned THRESHOLD    = 16,
   parameter int unsigned DECAY_PERIOD = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid_i,
   input  logic       alu_used_i,
   input  logic       mult_used_i,
   input  logic [3:0] err_replica_i,
   input  logic       clear_i,
   output logic [3:0] permanent_faulty_alu_o,
   output logic [3:0] permanent_faulty_mult_o,
   output logic       fault_event_o,
   output logic       fault_is_mult_o,
   output logic [1:0] fault_id_o,
   output logic       ambiguous_o
);

   typedef enum logic {HEALTHY = 1'b0, FAULTY = 1'b1} rep_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

   if ((THRESHOLD < 1) || (THRESHOLD >= (64'd1 << CNT_W))) begin : g_bad_threshold
      $error("THRESHOLD must lie in 1..2^CNT_W-1");
   end
   if (DECAY_PERIOD < 1) begin : g_bad_decay
      $error("DECAY_PERIOD must be at least 1");
   end

   // Index 0 = ALU bank, index 1 = MULT bank.
   logic [CNT_W-1:0] cnt_q [2][4];
   logic [CNT_W-1:0] cnt_d [2][4];
   rep_state_e       st_q  [2][4];
   rep_state_e       st_d  [2][4];

`ifdef PFD_LEAKY_DECAY_EN
   localparam int unsigned      CLEAN_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [CLEAN_W-1:0] CLEAN_WRAP = CLEAN_W'(DECAY_PERIOD - 1);
   logic [CLEAN_W-1:0] clean_q [2][4];
   logic [CLEAN_W-1:0] clean_d [2][4];
`endif

   logic       sel;
   logic       accept;
   logic [3:0] err_m;
   logic [2:0] n_err;
   logic [3:0] new_flag;
   logic       id_found;
   logic       ev_d;
   logic       is_mult_d;
   logic [1:0] id_d;
   logic       amb_d;

   always_comb begin
      sel    = ~alu_used_i;
      accept = sample_valid_i & (alu_used_i | mult_used_i);
      err_m  = '0;
      n_err  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         err_m[i] = err_replica_i[i] & (st_q[sel][i] == HEALTHY);
         n_err    = n_err + {2'b00, err_m[i]};
      end

      cnt_d    = cnt_q;
      st_d     = st_q;
      new_flag = '0;
`ifdef PFD_LEAKY_DECAY_EN
      clean_d  = clean_q;
`endif

      if (accept && (n_err <= 3'd1)) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (st_q[sel][i] == HEALTHY) begin
               if (err_m[i]) begin
                  if (cnt_q[sel][i] != CNT_MAX) cnt_d[sel][i] = cnt_q[sel][i] + 1'b1;
                  if (cnt_d[sel][i] >= THR) begin
                     st_d[sel][i] = FAULTY;
                     new_flag[i]  = 1'b1;
                  end
`ifdef PFD_LEAKY_DECAY_EN
                  clean_d[sel][i] = '0;
               end else if (clean_q[sel][i] == CLEAN_WRAP) begin
                  // A full period of clean participation retires one error.
                  clean_d[sel][i] = '0;
                  if (cnt_q[sel][i] != '0) cnt_d[sel][i] = cnt_q[sel][i] - 1'b1;
               end else begin
                  clean_d[sel][i] = clean_q[sel][i] + 1'b1;
`endif
               end
            end
         end
      end

      ev_d      = |new_flag;
      is_mult_d = sel & ev_d;
      id_d      = '0;
      id_found  = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (new_flag[i] && !id_found) begin
            id_d     = 2'(i);
            id_found = 1'b1;
         end
      end
      amb_d = accept & (n_err > 3'd1);

      // Clear wins over a simultaneous sample and reports nothing.
      if (clear_i) begin
         cnt_d     = '{default: '0};
         st_d      = '{default: HEALTHY};
`ifdef PFD_LEAKY_DECAY_EN
         clean_d   = '{default: '0};
`endif
         ev_d      = 1'b0;
         is_mult_d = 1'b0;
         id_d      = '0;
         amb_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q           <= '{default: '0};
         st_q            <= '{default: HEALTHY};
`ifdef PFD_LEAKY_DECAY_EN
         clean_q         <= '{default: '0};
`endif
         fault_event_o   <= 1'b0;
         fault_is_mult_o <= 1'b0;
         fault_id_o      <= '0;
         ambiguous_o     <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         st_q            <= st_d;
`ifdef PFD_LEAKY_DECAY_EN
         clean_q         <= clean_d;
`endif
         fault_event_o   <= ev_d;
         fault_is_mult_o <= is_mult_d;
         fault_id_o      <= id_d;
         ambiguous_o     <= amb_d;
      end
   end

   always_comb begin
      permanent_faulty_alu_o  = '0;
      permanent_faulty_mult_o = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         permanent_faulty_alu_o[i]  = (st_q[0][i] == FAULTY);
         permanent_faulty_mult_o[i] = (st_q[1][i] == FAULTY);
      end
   end

endmodule

// File: tb/tb_cv32e40p_permanent_fault_detector.sv
// Scoreboard bench for cv32e40p_permanent_fault_detector: directed scenarios plus random traffic
// against a behavioural model (decay scenario only when PFD_LEAKY_DECAY_EN is defined).
module tb_cv32e40p_permanent_fault_detector;

   localparam int TH      = 16;
   localparam int CMAX    = 255;
   localparam int DPERIOD = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_valid_i, alu_used_i, mult_used_i, clear_i;
   logic [3:0] err_replica_i;
   logic [3:0] permanent_faulty_alu_o, permanent_faulty_mult_o;
   logic       fault_event_o, fault_is_mult_o, ambiguous_o;
   logic [1:0] fault_id_o;

   cv32e40p_permanent_fault_detector #(
      .CNT_W        (8),
      .THRESHOLD    (TH),
      .DECAY_PERIOD (DPERIOD)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .sample_valid_i          (sample_valid_i),
      .alu_used_i              (alu_used_i),
      .mult_used_i             (mult_used_i),
      .err_replica_i           (err_replica_i),
      .clear_i                 (clear_i),
      .permanent_faulty_alu_o  (permanent_faulty_alu_o),
      .permanent_faulty_mult_o (permanent_faulty_mult_o),
      .fault_event_o           (fault_event_o),
      .fault_is_mult_o         (fault_is_mult_o),
      .fault_id_o              (fault_id_o),
      .ambiguous_o             (ambiguous_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] fa;
      logic [3:0] fm;
      logic       ev;
      logic       im;
      logic [1:0] id;
      logic       amb;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_events = 0;

   // Behavioural model state: plain integers per bank/replica.
   int m_cnt   [2][4];
   bit m_flag  [2][4];
   int m_clean [2][4];

   function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 4; i++) begin
            m_cnt[b][i] = 0; m_flag[b][i] = 0; m_clean[b][i] = 0;
         end
   endfunction

   function automatic exp_t model_apply(bit v, bit a, bit m, logic [3:0] err, bit clr);
      exp_t e;
      int   b, nerr;
      e.ev = 0; e.im = 0; e.id = 0; e.amb = 0;
      if (clr) begin
         model_reset();
      end else if (v && (a || m)) begin
         b    = a ? 0 : 1;
         nerr = 0;
         for (int i = 0; i < 4; i++) if (err[i] && !m_flag[b][i]) nerr++;
         if (nerr > 1) e.amb = 1;
         else begin
            for (int i = 0; i < 4; i++) begin
               if (m_flag[b][i]) continue;
               if (err[i]) begin
                  m_cnt[b][i]   = (m_cnt[b][i] + 1 > CMAX) ? CMAX : m_cnt[b][i] + 1;
                  m_clean[b][i] = 0;
                  if (m_cnt[b][i] >= TH) begin
                     m_flag[b][i] = 1; e.ev = 1; e.im = (b == 1); e.id = 2'(i);
                  end
               end else begin
`ifdef PFD_LEAKY_DECAY_EN
                  m_clean[b][i]++;
                  if (m_clean[b][i] == DPERIOD) begin
                     m_clean[b][i] = 0;
                     if (m_cnt[b][i] > 0) m_cnt[b][i]--;
                  end
`endif
               end
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         e.fa[i] = m_flag[0][i];
         e.fm[i] = m_flag[1][i];
      end
      return e;
   endfunction

   task automatic step(input bit v, input bit a, input bit m, input logic [3:0] err, input bit clr);
      @(negedge clk);
      sample_valid_i = v; alu_used_i = a; mult_used_i = m; err_replica_i = err; clear_i = clr;
      exp_q.push_back(model_apply(v, a, m, err, clr));
   endtask

   task automatic idle();
      step(0, 0, 0, 4'h0, 0);
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_alu"},  {4'h0, permanent_faulty_alu_o},  8'h0);
      chk({tag, "_mult"}, {4'h0, permanent_faulty_mult_o}, 8'h0);
      chk({tag, "_ev"},   {7'h0, fault_event_o},           8'h0);
      chk({tag, "_im"},   {7'h0, fault_is_mult_o},         8'h0);
      chk({tag, "_id"},   {6'h0, fault_id_o},              8'h0);
      chk({tag, "_amb"},  {7'h0, ambiguous_o},             8'h0);
   endtask

   // Monitor: pops one expectation per issued sample, just after the edge that consumed it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (fault_event_o) n_events++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("flags_alu",  {4'h0, permanent_faulty_alu_o},  {4'h0, e.fa});
         chk("flags_mult", {4'h0, permanent_faulty_mult_o}, {4'h0, e.fm});
         chk("ambiguous",  {7'h0, ambiguous_o},             {7'h0, e.amb});
         chk("event",      {7'h0, fault_event_o},           {7'h0, e.ev});
         if (e.ev) begin
            chk("event_is_mult", {7'h0, fault_is_mult_o}, {7'h0, e.im});
            chk("event_id",      {6'h0, fault_id_o},      {6'h0, e.id});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev0, r;
      logic [3:0] err;
      rst = 1'b1;
      sample_valid_i = 0; alu_used_i = 0; mult_used_i = 0; err_replica_i = '0; clear_i = 0;
      model_reset();
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // 16 ALU1 errors flag ALU1 with an event naming replica 1.
      for (int k = 0; k < 16; k++) step(1, 1, 0, 4'b0010, 0);
      idle();
      chk("alu1_flagged", {4'h0, permanent_faulty_alu_o}, 8'h02);

      // 15 MULT2 errors, then a clear together with the 16th sample.
      step(0, 0, 0, 4'h0, 1);
      for (int k = 0; k < 15; k++) step(1, 0, 1, 4'b0100, 0);
      step(1, 0, 1, 4'b0100, 1);
      idle();
      chk("clear_mult_flags", {4'h0, permanent_faulty_mult_o}, 8'h00);
      for (int k = 0; k < 15; k++) step(1, 0, 1, 4'b0100, 0);
      idle();
      chk("clear_zeroed_cnt", {4'h0, permanent_faulty_mult_o}, 8'h00);

      // Ambiguous sample, then masking of a flagged replica.
      step(0, 0, 0, 4'h0, 1);
      step(1, 1, 1, 4'b0011, 0);
      for (int k = 0; k < 16; k++) step(1, 1, 0, 4'b0100, 0);
      for (int k = 0; k < 15; k++) step(1, 1, 0, 4'b0101, 0);
      idle();
      chk("masked_no_flag", {4'h0, permanent_faulty_alu_o}, 8'h04);
      step(1, 1, 0, 4'b0101, 0);
      idle();
      chk("masked_alu0", {4'h0, permanent_faulty_alu_o}, 8'h05);

      // Flag all four ALU replicas in order.
      step(0, 0, 0, 4'h0, 1);
      idle();
      ev0 = n_events;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 16; j++) step(1, 1, 0, 4'(1 << k), 0);
      idle();
      idle();
      chk("all_alu_faulty", {4'h0, permanent_faulty_alu_o}, 8'h0F);
      chk("four_events", 8'(n_events - ev0), 8'd4);

      // Asynchronous reset mid-count on MULT3.
      step(0, 0, 0, 4'h0, 1);
      for (int k = 0; k < 10; k++) step(1, 0, 1, 4'b1000, 0);
      @(negedge clk);
      sample_valid_i = 0; alu_used_i = 0; mult_used_i = 0; err_replica_i = '0; clear_i = 0;
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      model_reset();
      #1 rst = 1'b0;
      for (int k = 0; k < 15; k++) step(1, 0, 1, 4'b1000, 0);
      idle();
      chk("rst_15_no_flag", {4'h0, permanent_faulty_mult_o}, 8'h00);
      step(1, 0, 1, 4'b1000, 0);
      idle();
      chk("rst_16_flag", {4'h0, permanent_faulty_mult_o}, 8'h08);

`ifdef PFD_LEAKY_DECAY_EN
      step(0, 0, 0, 4'h0, 1);
      for (int k = 0; k < 15; k++) step(1, 1, 0, 4'b0001, 0);
      for (int k = 0; k < 64; k++) step(1, 1, 0, 4'b0000, 0);
      step(1, 1, 0, 4'b0001, 0);
      idle();
      chk("decay_no_flag", {4'h0, permanent_faulty_alu_o}, 8'h00);
      step(1, 1, 0, 4'b0001, 0);
      idle();
      chk("decay_flag", {4'h0, permanent_faulty_alu_o}, 8'h01);
`endif

      // Random traffic against the model.
      step(0, 0, 0, 4'h0, 1);
      for (int k = 0; k < 800; k++) begin
         r = $urandom_range(0, 3);
         if (r == 0)      err = 4'h0;
         else if (r == 3) err = 4'($urandom);
         else             err = 4'(1 << $urandom_range(0, 3));
         step(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), err,
              ($urandom_range(0, 99) == 0));
      end
      idle();
      idle();
      @(negedge clk);
      chk("queue_drained", 8'(exp_q.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
